sd_beat_packer: RTL and testbench

//   Sits between the SD sector reader (16-bit rd words) and the AXI write

---
 rtl/sd_beat_packer.sv | 160 ++++++++++++++++
 tb/tb_sd_beat_packer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sd_beat_packer.sv
// sd_beat_packer: packs a 16-bit SD read word stream into wide beats with
// byte strobes and a last flag, then buffers the beats in a first-word-fall-
// through FIFO. The SD side has no ready: beats that find the FIFO full are
// dropped and flagged through a sticky overflow bit.

// One lane of the pack register. Holds its word until the beat is pushed and
// presents its slice of the outgoing beat (zero above the current lane).
module sd_beat_lane #(
  parameter int IN_WIDTH = 16,
  parameter int LW       = 4,
  parameter int IDX      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  in_en,
  input  logic                  push,
  input  logic [LW-1:0]         lane,
  input  logic [IN_WIDTH-1:0]   in_data,
  output logic [IN_WIDTH-1:0]   beat_word,
  output logic [IN_WIDTH/8-1:0] beat_strb
);
  localparam logic [LW-1:0] MY_LANE = LW'(IDX);

  logic [IN_WIDTH-1:0] held;

  // Capture the word addressed to this lane; a push empties the whole register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            held <= '0;
    else if (clr)       held <= '0;
    else if (in_en) begin
      if (push)                  held <= '0;
      else if (lane == MY_LANE)  held <= in_data;
    end
  end

  // The current word bypasses the register so the completing beat needs no
  // extra cycle; lanes above the current one are forced to zero.
  always_comb begin
    beat_word = '0;
    if (lane == MY_LANE)     beat_word = in_data;
    else if (lane > MY_LANE) beat_word = held;
  end

  assign beat_strb = (lane >= MY_LANE) ? '1 : '0;
endmodule

module sd_beat_packer #(
  parameter int IN_WIDTH   = 16,
  parameter int DATA_WIDTH = 256,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clr,
  input  logic                          in_en,
  input  logic [IN_WIDTH-1:0]           in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [STRB_WIDTH-1:0]         out_strb,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   beat_cnt,
  output logic                          overflow
);
  localparam int LANES = DATA_WIDTH / IN_WIDTH;
  localparam int BPL   = IN_WIDTH / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
  localparam logic [AW:0]   DEPTH_LV  = (AW+1)'(FIFO_DEPTH);

  // ---------------- packing ----------------
  logic [LW-1:0]                     lane;
  logic [LANES-1:0][IN_WIDTH-1:0]    beat_data;
  logic [LANES-1:0][BPL-1:0]         beat_strb;
  logic                              push_due;

  assign push_due = in_en && !clr && ((lane == LAST_LANE) || in_last);

  // Lane counter: advances per word, returns to 0 after every pushed beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         lane <= '0;
    else if (clr)    lane <= '0;
    else if (in_en)  lane <= push_due ? '0 : lane + 1'b1;
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sd_beat_lane #(
      .IN_WIDTH (IN_WIDTH),
      .LW       (LW),
      .IDX      (g)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .in_en     (in_en),
      .push      (push_due),
      .lane      (lane),
      .in_data   (in_data),
      .beat_word (beat_data[g]),
      .beat_strb (beat_strb[g])
    );
  end

  // ---------------- beat FIFO ----------------
  logic [DATA_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [STRB_WIDTH-1:0] mem_strb [FIFO_DEPTH];
  logic                  mem_last [FIFO_DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, level;
  logic                  pop, accept, shown;

  assign level     = wr_ptr - rd_ptr;
  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready && !clr;
  // A full FIFO still takes the beat when the head leaves in the same cycle.
  assign accept    = push_due && ((level < DEPTH_LV) || pop);

  // Storage has no reset; the head is masked until something was written.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_data[wr_ptr[AW-1:0]] <= beat_data;
      mem_strb[wr_ptr[AW-1:0]] <= beat_strb;
      mem_last[wr_ptr[AW-1:0]] <= in_last;
    end
  end

  // Pointers, head-visible flag, beat counter and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      shown    <= 1'b0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      shown    <= 1'b0;
      beat_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr   <= wr_ptr + 1'b1;
        shown    <= 1'b1;
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_due && !accept) overflow <= 1'b1;
    end
  end

  assign fifo_level = level;
  assign out_data   = shown ? mem_data[rd_ptr[AW-1:0]] : '0;
  assign out_strb   = shown ? mem_strb[rd_ptr[AW-1:0]] : '0;
  assign out_last   = shown ? mem_last[rd_ptr[AW-1:0]] : 1'b0;
endmodule

// File: tb/tb_sd_beat_packer.sv
// Directed bench for sd_beat_packer (16-bit words, 256-bit beats, depth 16).
module tb_sd_beat_packer;
  logic         clk = 1'b0;
  logic         rst, clr, in_en, in_last, out_ready;
  logic [15:0]  in_data;
  logic         out_valid, out_last, overflow;
  logic [255:0] out_data;
  logic [31:0]  out_strb;
  logic [4:0]   fifo_level;
  logic [15:0]  beat_cnt;

  int tests = 0;
  int fails = 0;

  sd_beat_packer dut (
    .clk(clk), .rst(rst), .clr(clr), .in_en(in_en), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_strb(out_strb), .out_last(out_last),
    .fifo_level(fifo_level), .beat_cnt(beat_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Present one word for one edge; returns #1 after that edge.
  task automatic put(input logic [15:0] d, input logic l);
    in_en = 1'b1; in_data = d; in_last = l;
    @(posedge clk); #1;
    in_en = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 0; in_en = 0; in_last = 0; in_data = 0; out_ready = 0;
    #12; rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({out_valid, out_last, overflow, fifo_level, beat_cnt} !== '0 || out_data !== '0 || out_strb !== '0) begin
      fails++;
      $display("FAIL reset: valid=%0b last=%0b ovf=%0b level=%0d cnt=%0d strb=%h", out_valid, out_last, overflow, fifo_level, beat_cnt, out_strb);
    end
  endtask

  task automatic test_single_beat();
    logic [255:0] exp;
    out_ready = 1'b1;
    do_clr();
    for (int k = 0; k < 16; k++) begin
      exp[k*16 +: 16] = 16'(k + 1);
      put(16'(k + 1), k == 15);
    end
    tests++;
    if (out_valid !== 1'b1 || out_data !== exp || out_strb !== 32'hFFFF_FFFF || out_last !== 1'b1 || beat_cnt !== 16'd1) begin
      fails++;
      $display("FAIL single_beat: valid=%0b last=%0b cnt=%0d strb=%h data=%h want %h", out_valid, out_last, beat_cnt, out_strb, out_data, exp);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL single_beat_pop: valid=%0b want 0", out_valid); end
  endtask

  task automatic test_sector();
    logic [255:0] exp;
    out_ready = 1'b1;
    do_clr();
    for (int i = 0; i < 256; i++) begin
      exp[(i % 16)*16 +: 16] = 16'(i);
      put(16'(i), i == 255);
      if (i % 16 == 15) begin
        tests++;
        if (out_valid !== 1'b1 || out_data !== exp || out_strb !== 32'hFFFF_FFFF || out_last !== (i == 255)) begin
          fails++;
          $display("FAIL sector_beat%0d: valid=%0b last=%0b strb=%h data=%h want %h", i/16, out_valid, out_last, out_strb, out_data, exp);
        end
      end
    end
    tests++;
    if (overflow !== 1'b0 || beat_cnt !== 16'd16) begin
      fails++; $display("FAIL sector_end: ovf=%0b cnt=%0d want 0/16", overflow, beat_cnt);
    end
  endtask

  task automatic test_partial();
    out_ready = 1'b0;
    do_clr();
    put(16'hAAAA, 0); put(16'hBBBB, 0); put(16'hCCCC, 1);
    tests++;
    if (out_valid !== 1'b1 || out_strb !== 32'h0000_003F || out_data !== {208'h0, 48'hCCCC_BBBB_AAAA} || out_last !== 1'b1) begin
      fails++;
      $display("FAIL partial: valid=%0b last=%0b strb=%h data=%h", out_valid, out_last, out_strb, out_data);
    end
  endtask

  task automatic test_overflow();
    logic [255:0] exp;
    out_ready = 1'b0;
    do_clr();
    for (int b = 0; b < 17; b++)
      for (int k = 0; k < 16; k++) put({8'(b), 8'(k)}, 0);
    tests++;
    if (fifo_level !== 5'd16 || overflow !== 1'b1 || beat_cnt !== 16'd16) begin
      fails++; $display("FAIL overflow: level=%0d ovf=%0b cnt=%0d want 16/1/16", fifo_level, overflow, beat_cnt);
    end
    out_ready = 1'b1;
    for (int b = 0; b < 16; b++) begin
      for (int k = 0; k < 16; k++) exp[k*16 +: 16] = {8'(b), 8'(k)};
      tests++;
      if (out_valid !== 1'b1 || out_data !== exp || out_last !== 1'b0) begin
        fails++; $display("FAIL drain_beat%0d: valid=%0b last=%0b data=%h want %h", b, out_valid, out_last, out_data, exp);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin
      fails++; $display("FAIL drain_empty: valid=%0b level=%0d", out_valid, fifo_level);
    end
  endtask

  task automatic test_full_with_pop();
    out_ready = 1'b0;
    do_clr();
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 16; k++) put({8'(b), 8'(k)}, 0);
    for (int k = 0; k < 15; k++) put({8'd16, 8'(k)}, 0);
    out_ready = 1'b1;
    put({8'd16, 8'd15}, 0);
    out_ready = 1'b0;
    tests++;
    if (overflow !== 1'b0 || fifo_level !== 5'd16 || beat_cnt !== 16'd17 || out_data[15:0] !== 16'h0100) begin
      fails++; $display("FAIL full_pop: ovf=%0b level=%0d cnt=%0d head=%h want 0/16/17/0100", overflow, fifo_level, beat_cnt, out_data[15:0]);
    end
  endtask

  task automatic test_clr();
    // FIFO is still full: this beat is dropped
    for (int k = 0; k < 16; k++) put(16'h7700 + 16'(k), 0);
    tests++;
    if (overflow !== 1'b1 || beat_cnt !== 16'd17) begin
      fails++; $display("FAIL pre_clr_ovf: ovf=%0b cnt=%0d want 1/17", overflow, beat_cnt);
    end
    for (int k = 0; k < 5; k++) put(16'h5500 + 16'(k), 0);
    // clr wins over a simultaneous word
    clr = 1'b1; in_en = 1'b1; in_data = 16'hDEAD; in_last = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_en = 1'b0; in_last = 1'b0;
    tests++;
    if ({out_valid, out_last, overflow, fifo_level, beat_cnt} !== '0 || out_data !== '0 || out_strb !== '0) begin
      fails++; $display("FAIL clr: valid=%0b ovf=%0b level=%0d cnt=%0d data=%h", out_valid, overflow, fifo_level, beat_cnt, out_data);
    end
    put(16'h1111, 0); put(16'h2222, 1);
    tests++;
    if (out_data !== {224'h0, 32'h2222_1111} || out_strb !== 32'h0000_000F || fifo_level !== 5'd1 || beat_cnt !== 16'd1) begin
      fails++; $display("FAIL after_clr: data=%h strb=%h level=%0d cnt=%0d", out_data, out_strb, fifo_level, beat_cnt);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) put(16'h3300 + 16'(k), 0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({out_valid, out_last, overflow, fifo_level, beat_cnt} !== '0 || out_data !== '0 || out_strb !== '0) begin
      fails++; $display("FAIL async_reset: valid=%0b level=%0d cnt=%0d data=%h", out_valid, fifo_level, beat_cnt, out_data);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    put(16'h0A0A, 1);
    tests++;
    if (out_data !== {240'h0, 16'h0A0A} || out_strb !== 32'h0000_0003 || beat_cnt !== 16'd1 || out_last !== 1'b1) begin
      fails++; $display("FAIL after_reset: data=%h strb=%h cnt=%0d last=%0b", out_data, out_strb, beat_cnt, out_last);
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_sector();
    test_partial();
    test_overflow();
    test_full_with_pop();
    test_clr();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
